dm_lsu: RTL and testbench

//   Load/store unit directly downstream of the ALU. Takes the ALU result as the effective address and issues one

---
 rtl/dm_lsu.sv | 183 ++++++++++++++++++
 tb/tb_dm_lsu.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_lsu.sv
// dm_lsu: load/store unit that sits directly after the ALU.
// The ALU result is the effective address. Each load or store becomes exactly one
// request/acknowledge transaction on the data bus. The unit drives the byte enables,
// replicates store data across the lanes, and zero- or sign-extends load data.
// It holds the CPU in stall until the access completes, errors or times out.
//
// Optional feature macro: LSU_MISALIGN_EXC_EN
//   defined   : a misaligned half/word access is refused without any bus traffic and
//               retires with misalign_o=1.
//   undefined : the offending low address bits are ignored and misalign_o is always 0.
//
// Ports:
//   clk, rstn                  clock (rising edge), asynchronous active-low reset
//   mem_rd_i, mem_wr_i         load/store request, held by the CPU while stall_o=1
//   dm_ctrl_i                  000 word, 001 hu, 010 hs, 011 bu, 100 bs, others = word
//   addr_i, wdata_i            byte address and store data
//   rdata_o                    extended load data, valid while done_o=1
//   stall_o, done_o            pipeline hold, one-cycle completion strobe
//   err_o, misalign_o          bus timeout / misaligned access, valid with done_o
//   bus_req_o ... bus_rdata_i  data bus (request held until bus_ack_i)
//   fsm_state_o                debug view of the FSM state (0 IDLE, 1 REQ, 2 RESP)
//
// Handshake: bus_req_o stays high, with address, enables and write data stable, until
// a cycle in which bus_ack_i=1. That cycle completes the transfer, and on a read
// bus_rdata_i is taken in the same cycle. An ack seen while no request is outstanding
// is ignored.
module dm_lsu #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_rd_i,
  input  logic        mem_wr_i,
  input  logic [2:0]  dm_ctrl_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        err_o,
  output logic        misalign_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic [1:0]  fsm_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] a_lo;    // latched address offset, used to pick the read lane
  logic       l_half;
  logic       l_byte;
  logic       l_sgn;

  logic       req_c;
  logic       half_c;
  logic       byte_c;
  logic       sgn_c;
  logic       mis_c;
  logic [3:0] be_c;
  logic [31:0] wd_c;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ext_c;

  assign req_c  = mem_rd_i | mem_wr_i;
  assign half_c = (dm_ctrl_i == 3'b001) | (dm_ctrl_i == 3'b010);
  assign byte_c = (dm_ctrl_i == 3'b011) | (dm_ctrl_i == 3'b100);
  assign sgn_c  = (dm_ctrl_i == 3'b010) | (dm_ctrl_i == 3'b100);

`ifdef LSU_MISALIGN_EXC_EN
  assign mis_c = (half_c & addr_i[0]) | (~half_c & ~byte_c & (addr_i[1:0] != 2'b00));
`else
  assign mis_c = 1'b0;
`endif

  always_comb begin
    be_c = 4'b1111;
    wd_c = wdata_i;
    if (byte_c) begin
      be_c = 4'b0001 << addr_i[1:0];
      wd_c = {4{wdata_i[7:0]}};
    end else if (half_c) begin
      be_c = addr_i[1] ? 4'b1100 : 4'b0011;
      wd_c = {2{wdata_i[15:0]}};
    end
  end

  // Lane select and extension work on the latched offset/size, because the read
  // word arrives several cycles after the request was accepted.
  always_comb begin
    lane_b = bus_rdata_i[{a_lo, 3'b000} +: 8];
    lane_h = a_lo[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    ext_c  = bus_rdata_i;
    if (l_byte) begin
      ext_c = {{24{l_sgn & lane_b[7]}}, lane_b};
    end else if (l_half) begin
      ext_c = {{16{l_sgn & lane_h[15]}}, lane_h};
    end
  end

  // The stall request is combinational in IDLE so that the PC holds in the accept
  // cycle. It is gated by rstn so that it also drops immediately during reset.
  assign stall_o     = rstn & (((state == IDLE) & req_c) | (state == REQ));
  assign fsm_state_o = state;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      a_lo        <= 2'b00;
      l_half      <= 1'b0;
      l_byte      <= 1'b0;
      l_sgn       <= 1'b0;
      rdata_o     <= 32'd0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      misalign_o  <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'd0;
      bus_be_o    <= 4'd0;
      bus_wdata_o <= 32'd0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_c) begin
            bus_addr_o  <= {addr_i[31:2], 2'b00};
            bus_be_o    <= be_c;
            bus_wdata_o <= wd_c;
            bus_we_o    <= mem_wr_i;   // rd and wr together count as a write
            a_lo        <= addr_i[1:0];
            l_half      <= half_c;
            l_byte      <= byte_c;
            l_sgn       <= sgn_c;
            cnt         <= 8'd0;
            err_o       <= 1'b0;
            if (mis_c) begin
              state      <= RESP;
              done_o     <= 1'b1;
              misalign_o <= 1'b1;
              rdata_o    <= 32'd0;
            end else begin
              state     <= REQ;
              bus_req_o <= 1'b1;
            end
          end
        end
        REQ: begin
          cnt <= cnt + 8'd1;
          if (bus_ack_i) begin
            // An ack in the same cycle as the timeout still counts as a success.
            state     <= RESP;
            bus_req_o <= 1'b0;
            done_o    <= 1'b1;
            rdata_o   <= ext_c;
          end else if (cnt == 8'(TIMEOUT_CYC - 1)) begin
            state     <= RESP;
            bus_req_o <= 1'b0;
            done_o    <= 1'b1;
            err_o     <= 1'b1;
            rdata_o   <= 32'd0;
          end
        end
        RESP: begin
          // The instruction retires here, so a request still held is not reissued.
          state      <= IDLE;
          err_o      <= 1'b0;
          misalign_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_lsu.sv
module tb_dm_lsu;

  localparam int TMO = 16;

  logic        clk;
  logic        rstn;
  logic        mem_rd_i;
  logic        mem_wr_i;
  logic [2:0]  dm_ctrl_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        stall_o;
  logic        done_o;
  logic        err_o;
  logic        misalign_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic [1:0]  fsm_state_o;

  int n_tests = 0;
  int n_fail  = 0;

  dm_lsu #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rstn(rstn), .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i),
    .dm_ctrl_i(dm_ctrl_i), .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o),
    .stall_o(stall_o), .done_o(done_o), .err_o(err_o), .misalign_o(misalign_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i),
    .bus_rdata_i(bus_rdata_i), .fsm_state_o(fsm_state_o)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One access: stimulus and the outputs it must produce.
  // lat = REQ cycles without ack before the ack cycle (>= TMO means never ack).
  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_addr;
    logic        e_we;
    logic [31:0] e_rdata;
    logic        e_err;
    logic        e_mis;
    int          e_cycles;
    int          e_reqs;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic rd, input logic wr,
                              input logic [2:0] ctrl, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input int lat,
                              input logic [3:0] e_be, input logic [31:0] e_wdata,
                              input logic [31:0] e_addr, input logic e_we,
                              input logic [31:0] e_rdata, input logic e_err,
                              input logic e_mis, input int e_cycles, input int e_reqs);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.ctrl = ctrl; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.lat = lat;
    v.e_be = e_be; v.e_wdata = e_wdata; v.e_addr = e_addr; v.e_we = e_we;
    v.e_rdata = e_rdata; v.e_err = e_err; v.e_mis = e_mis;
    v.e_cycles = e_cycles; v.e_reqs = e_reqs;
    return v;
  endfunction

  // Reference model: computes the expected outcome from access size, lane offset
  // and plain shifts/multiplies, independent of how the design is built.
  function automatic vec_t model(input vec_t s);
    vec_t v = s;
    int nb;
    int off;
    longint unsigned mask;
    longint unsigned lane;
    bit sgn;
    bit mis;
    nb  = (s.ctrl == 3'd1 || s.ctrl == 3'd2) ? 2 : (s.ctrl == 3'd3 || s.ctrl == 3'd4) ? 1 : 4;
    sgn = (s.ctrl == 3'd2 || s.ctrl == 3'd4);
    off = (nb == 4) ? 0 : (nb == 2) ? 2 * int'(s.addr[1]) : int'(s.addr[1:0]);
    mis = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
    mis = (nb == 2 && s.addr[0]) || (nb == 4 && s.addr[1:0] != 2'b00);
`endif
    mask = (64'd1 << (8 * nb)) - 1;
    v.e_be    = 4'(((1 << nb) - 1) << off);
    v.e_wdata = (nb == 1) ? s.wdata[7:0] * 32'h01010101 :
                (nb == 2) ? s.wdata[15:0] * 32'h00010001 : s.wdata;
    v.e_addr  = s.addr & 32'hFFFF_FFFC;
    v.e_we    = s.wr;
    lane = (64'(s.rdata) >> (8 * off)) & mask;
    if (sgn && lane[8 * nb - 1]) lane = lane | ~mask;
    v.e_mis = mis;
    if (mis) begin
      v.e_rdata = 0; v.e_err = 0; v.e_cycles = 2; v.e_reqs = 0;
    end else if (s.lat >= TMO) begin
      v.e_rdata = 0; v.e_err = 1; v.e_cycles = TMO + 2; v.e_reqs = TMO;
    end else begin
      v.e_rdata = lane[31:0]; v.e_err = 0; v.e_cycles = s.lat + 3; v.e_reqs = s.lat + 1;
    end
    return v;
  endfunction

  // driver: issues one access, plays the bus slave, and checks the outcome.
  task automatic run_vec(input vec_t v);
    int cyc = 1;
    int reqs = 0;
    int stalls = 0;
    bit seen = 0;
    bit fin = 0;
    logic [3:0]  g_be = 0;
    logic [31:0] g_wd = 0;
    logic [31:0] g_ad = 0;
    logic        g_we = 0;
    logic [31:0] g_rd = 0;
    logic        g_er = 0;
    logic        g_mi = 0;
    @(posedge clk); #1;
    mem_rd_i = v.rd; mem_wr_i = v.wr; dm_ctrl_i = v.ctrl;
    addr_i = v.addr; wdata_i = v.wdata; bus_rdata_i = v.rdata;
    while (!fin && cyc <= 40) begin
      @(negedge clk);
      if (stall_o) stalls++;
      bus_ack_i = 1'b0;
      if (bus_req_o) begin
        reqs++;
        if (!seen) begin
          seen = 1; g_be = bus_be_o; g_wd = bus_wdata_o; g_ad = bus_addr_o; g_we = bus_we_o;
        end
        if (reqs == v.lat + 1) bus_ack_i = 1'b1;
      end
      if (done_o) begin
        fin = 1;
        g_rd = rdata_o; g_er = err_o; g_mi = misalign_o;
        mem_rd_i = 0; mem_wr_i = 0;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!fin) begin
      n_tests++; n_fail++;
      $display("FAIL %s done: no done_o within 40 cycles", v.name);
      mem_rd_i = 0; mem_wr_i = 0; bus_ack_i = 0;
      return;
    end
    check({v.name, " cycles"}, 32'(cyc), 32'(v.e_cycles));
    check({v.name, " stall"}, 32'(stalls), 32'(v.e_cycles - 1));
    check({v.name, " reqs"}, 32'(reqs), 32'(v.e_reqs));
    check({v.name, " rdata"}, g_rd, v.e_rdata);
    check({v.name, " err"}, 32'(g_er), 32'(v.e_err));
    check({v.name, " mis"}, 32'(g_mi), 32'(v.e_mis));
    if (!v.e_mis) begin
      check({v.name, " be"}, 32'(g_be), 32'(v.e_be));
      check({v.name, " wdata"}, g_wd, v.e_wdata);
      check({v.name, " addr"}, g_ad, v.e_addr);
      check({v.name, " we"}, 32'(g_we), 32'(v.e_we));
    end
  endtask

  initial begin
    rstn = 0; mem_rd_i = 0; mem_wr_i = 0; dm_ctrl_i = 0; addr_i = 0; wdata_i = 0;
    bus_ack_i = 0; bus_rdata_i = 0;

    // Directed table: hand-derived expected values.
    vecs.push_back(mk("ld_word", 1, 0, 3'd0, 32'h100, 0, 32'hDEADBEEF, 0,
                      4'hF, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0, 3, 1));
    vecs.push_back(mk("ld_bs", 1, 0, 3'd4, 32'h103, 0, 32'h80112233, 0,
                      4'h8, 0, 32'h100, 0, 32'hFFFFFF80, 0, 0, 3, 1));
    vecs.push_back(mk("ld_bu", 1, 0, 3'd3, 32'h103, 0, 32'h80112233, 0,
                      4'h8, 0, 32'h100, 0, 32'h00000080, 0, 0, 3, 1));
    vecs.push_back(mk("st_half", 0, 1, 3'd1, 32'h202, 32'h1234ABCD, 0, 2,
                      4'hC, 32'hABCDABCD, 32'h200, 1, 0, 0, 0, 5, 3));
`ifdef LSU_MISALIGN_EXC_EN
    vecs.push_back(mk("ld_w_mis", 1, 0, 3'd0, 32'h101, 0, 32'h11223344, 0,
                      4'hF, 0, 32'h100, 0, 0, 0, 1, 2, 0));
    vecs.push_back(mk("ld_h_mis", 1, 0, 3'd1, 32'h103, 0, 32'h9ABC0000, 0,
                      4'hC, 0, 32'h100, 0, 0, 0, 1, 2, 0));
`else
    vecs.push_back(mk("ld_w_mis", 1, 0, 3'd0, 32'h101, 0, 32'h11223344, 0,
                      4'hF, 0, 32'h100, 0, 32'h11223344, 0, 0, 3, 1));
    vecs.push_back(mk("ld_h_mis", 1, 0, 3'd1, 32'h103, 0, 32'h9ABC0000, 0,
                      4'hC, 0, 32'h100, 0, 32'h00009ABC, 0, 0, 3, 1));
`endif
    vecs.push_back(mk("ld_hs", 1, 0, 3'd2, 32'h102, 0, 32'h80017777, 1,
                      4'hC, 0, 32'h100, 0, 32'hFFFF8001, 0, 0, 4, 2));
    vecs.push_back(mk("ld_hu_lo", 1, 0, 3'd1, 32'h100, 0, 32'hFFFF8765, 0,
                      4'h3, 0, 32'h100, 0, 32'h00008765, 0, 0, 3, 1));
    vecs.push_back(mk("ld_bu_l1", 1, 0, 3'd3, 32'h101, 0, 32'h0000AB00, 0,
                      4'h2, 0, 32'h100, 0, 32'h000000AB, 0, 0, 3, 1));
    vecs.push_back(mk("rdwr_byte", 1, 1, 3'd3, 32'h1000, 32'h0000005A, 0, 0,
                      4'h1, 32'h5A5A5A5A, 32'h1000, 1, 0, 0, 0, 3, 1));
    vecs.push_back(mk("ctrl_undef", 1, 0, 3'd7, 32'h40, 0, 32'h12345678, 0,
                      4'hF, 0, 32'h40, 0, 32'h12345678, 0, 0, 3, 1));
    vecs.push_back(mk("ack_at_tmo", 1, 0, 3'd0, 32'h80, 0, 32'hCAFEF00D, TMO - 1,
                      4'hF, 0, 32'h80, 0, 32'hCAFEF00D, 0, 0, TMO + 2, TMO));
    vecs.push_back(mk("timeout", 1, 0, 3'd0, 32'h84, 0, 32'h55555555, 255,
                      4'hF, 0, 32'h84, 0, 0, 1, 0, TMO + 2, TMO));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst bus_req", 32'(bus_req_o), 0);
    check("rst stall", 32'(stall_o), 0);
    check("rst done", 32'(done_o), 0);
    check("rst outs", {bus_addr_o ^ bus_wdata_o ^ rdata_o}, 0);
    check("rst flags", 32'({bus_we_o, bus_be_o, err_o, misalign_o}), 0);
    check("rst state", 32'(fsm_state_o), 0);
    @(posedge clk); #1 rstn = 1;

    foreach (vecs[i]) begin
      run_vec(vecs[i]);
      if (vecs[i].name == "timeout") begin
        // Spurious acks in IDLE must have no effect.
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          bus_ack_i = 1'b1;
          check("spur req", 32'(bus_req_o), 0);
          check("spur done", 32'(done_o), 0);
          check("spur stall", 32'(stall_o), 0);
        end
        @(negedge clk) bus_ack_i = 1'b0;
      end
    end

    // Reset while a request is in flight.
    @(posedge clk); #1;
    mem_rd_i = 1; dm_ctrl_i = 0; addr_i = 32'h300;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst req", 32'(bus_req_o), 1);
    #2 rstn = 0;
    #1;
    check("rst_req drop", 32'(bus_req_o), 0);
    check("rst_stall drop", 32'(stall_o), 0);
    @(posedge clk); #1;
    mem_rd_i = 0; rstn = 1;
    run_vec(vecs[0]);

    // Randomized accesses against the reference model.
    for (int n = 0; n < 40; n++) begin
      vec_t r;
      int rw;
      rw = $urandom_range(0, 2);
      r.name  = $sformatf("rnd%0d", n);
      r.rd    = (rw != 1);
      r.wr    = (rw != 0);
      r.ctrl  = 3'($urandom_range(0, 7));
      r.addr  = $urandom;
      r.wdata = $urandom;
      r.rdata = $urandom;
      r.lat   = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 3);
      run_vec(model(r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
